// File: rtl/seg7_scan4.sv
// rtl/seg7_scan4.sv - four-digit multiplexed BCD seven-segment scanner
// Each digit is shown for DIV clocks; the BCD word is only sampled at frame boundaries.
module seg7_scan4 #(
  parameter int DIV = 4
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic [15:0] iBCD,
  input  logic        iEN,
  input  logic        iLZB,
  output logic [3:0]  oAnodo,
  output logic [6:0]  oSeg,
  output logic        oFrame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          tick;
  logic          boundary;

  logic [3:0]    digit;
  logic          lz_blank;
  logic          blank;
  logic [6:0]    seg_dec;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  assign tick     = (presc == PRESC_MAX);
  assign boundary = tick && (idx == 2'd3);

  always_ff @(posedge iclk) begin
    if (!irst) begin
      presc  <= '0;
      idx    <= 2'd0;
      snap   <= 16'd0;
      oFrame <= 1'b0;
      oAnodo <= 4'hF;
      oSeg   <= 7'h7F;
    end else begin
      presc  <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
      // Snapshot only at the frame boundary so a frame never mixes two words.
      if (boundary) begin
        snap <= iBCD;
      end
      oFrame <= boundary;
      oAnodo <= an_next;
      oSeg   <= seg_next;
    end
  end

  always_comb begin
    digit    = 4'd0;
    lz_blank = 1'b0;
    case (idx)
      2'd0: begin
        digit    = snap[3:0];
        lz_blank = 1'b0;
      end
      2'd1: begin
        digit    = snap[7:4];
        lz_blank = (snap[15:4] == 12'd0);
      end
      2'd2: begin
        digit    = snap[11:8];
        lz_blank = (snap[15:8] == 8'd0);
      end
      default: begin
        digit    = snap[15:12];
        lz_blank = (snap[15:12] == 4'd0);
      end
    endcase

    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase

    blank    = !iEN || (iLZB && lz_blank);
    an_next  = blank ? 4'hF : ~(4'b0001 << idx);
    seg_next = blank ? 7'h7F : seg_dec;
  end

endmodule
